// File: rtl/occupancy_alloc_ctrl_pkg.sv
// Shared constants and FSM encoding for the occupied-width allocation controller.
package occupancy_alloc_ctrl_pkg;

   localparam int ID_W   = 4;
   localparam int OCC_W  = 7;
   localparam int ITEM_W = 5;

   localparam logic [OCC_W-1:0]  CAP     = 7'd127;
   localparam logic [ITEM_W-1:0] W_MIN   = 5'd4;
   localparam logic [ITEM_W-1:0] W_MAX   = 5'd16;
   localparam logic [ID_W-1:0]   FULL_ID = 4'd13;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_CHK,
      S_WR,
      S_RESP
   } state_e;

endpackage

// File: rtl/occupancy_fit_select.sv
// Three-way capacity check with fixed priority: candidate 0 beats 1 beats 2.
module occupancy_fit_select
   import occupancy_alloc_ctrl_pkg::*;
(
   input  logic [ITEM_W-1:0] item_i,
   input  logic [ID_W-1:0]   id1_i,
   input  logic [ID_W-1:0]   id2_i,
   input  logic [ID_W-1:0]   id3_i,
   input  logic [OCC_W-1:0]  width1_i,
   input  logic [OCC_W-1:0]  width2_i,
   input  logic [OCC_W-1:0]  width3_i,
   output logic              hit_o,
   output logic [1:0]        idx_o,
   output logic [OCC_W-1:0]  sum_o
);

   logic [ID_W-1:0]  id_k  [3];
   logic [OCC_W-1:0] occ_k [3];
   logic [OCC_W:0]   sum_k [3];
   logic [2:0]       fit_k;

   always_comb begin
      // NOTE: every variable gets a default before any conditional write,
      // otherwise synthesis infers a latch to hold the old value.
      hit_o = 1'b0;
      idx_o = '0;
      sum_o = '0;
      id_k[0]  = id1_i;
      id_k[1]  = id2_i;
      id_k[2]  = id3_i;
      occ_k[0] = width1_i;
      occ_k[1] = width2_i;
      occ_k[2] = width3_i;
      // Sum is one bit wider than occupancy so an overflow cannot wrap into a fit.
      for (int k = 0; k < 3; k++) begin
         sum_k[k] = {1'b0, occ_k[k]} + {{(OCC_W + 1 - ITEM_W){1'b0}}, item_i};
         fit_k[k] = (sum_k[k] <= {1'b0, CAP}) && (id_k[k] <= FULL_ID);
      end
      // Scan lowest priority first so the highest-priority fit is written last.
      for (int k = 2; k >= 0; k--) begin
         if (fit_k[k]) begin
            hit_o = 1'b1;
            idx_o = 2'(k);
            sum_o = sum_k[k][OCC_W-1:0];
         end
      end
   end

endmodule

// File: rtl/occupancy_alloc_ctrl.sv
// Requester side of the per-ID occupied-width memory: read three candidates,
// place the item in the first that fits, write back the added width, report.
module occupancy_alloc_ctrl
   import occupancy_alloc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [4:0] item_width,
   input  logic [3:0] id1,
   input  logic [3:0] id2,
   input  logic [3:0] id3,
   output logic       ram_en,
   output logic       ram_we,
   output logic [3:0] ram_write_id,
   output logic [4:0] ram_write_width,
   output logic [3:0] ram_id1,
   output logic [3:0] ram_id2,
   output logic [3:0] ram_id3,
   input  logic [6:0] ram_width1,
   input  logic [6:0] ram_width2,
   input  logic [6:0] ram_width3,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_hit,
   output logic [3:0] out_id,
   output logic [6:0] out_new_width,
   output logic       out_err
);

   state_e            state_q, state_d;
   logic [ITEM_W-1:0] item_q, item_d;
   logic [ID_W-1:0]   cid1_q, cid1_d, cid2_q, cid2_d, cid3_q, cid3_d;
   logic              hit_q, hit_d, err_q, err_d;
   logic [ID_W-1:0]   res_id_q, res_id_d;
   logic [OCC_W-1:0]  res_w_q, res_w_d;

   logic              fit_hit;
   logic [1:0]        fit_idx;
   logic [OCC_W-1:0]  fit_sum;
   logic [ID_W-1:0]   fit_id;
   logic              width_ok;

   occupancy_fit_select u_fit (
      .item_i   (item_q),
      .id1_i    (cid1_q),
      .id2_i    (cid2_q),
      .id3_i    (cid3_q),
      .width1_i (ram_width1),
      .width2_i (ram_width2),
      .width3_i (ram_width3),
      .hit_o    (fit_hit),
      .idx_o    (fit_idx),
      .sum_o    (fit_sum)
   );

   always_comb begin
      case (fit_idx)
         2'd0:    fit_id = cid1_q;
         2'd1:    fit_id = cid2_q;
         default: fit_id = cid3_q;
      endcase
   end

   assign width_ok = (item_width >= W_MIN) && (item_width <= W_MAX);

   always_comb begin
      state_d  = state_q;
      item_d   = item_q;
      cid1_d   = cid1_q;
      cid2_d   = cid2_q;
      cid3_d   = cid3_q;
      hit_d    = hit_q;
      err_d    = err_q;
      res_id_d = res_id_q;
      res_w_d  = res_w_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               item_d   = item_width;
               cid1_d   = id1;
               cid2_d   = id2;
               cid3_d   = id3;
               hit_d    = 1'b0;
               err_d    = !width_ok;
               res_id_d = FULL_ID;
               res_w_d  = '0;
               state_d  = width_ok ? S_RD : S_RESP;
            end
         end
         S_RD:  state_d = S_CHK;
         S_CHK: begin
            if (fit_hit) begin
               res_id_d = fit_id;
               res_w_d  = fit_sum;
               state_d  = S_WR;
            end else begin
               res_id_d = FULL_ID;
               res_w_d  = '0;
               state_d  = S_RESP;
            end
         end
         S_WR: begin
            hit_d   = 1'b1;
            state_d = S_RESP;
         end
         S_RESP: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge value, independent of statement order.
      if (!rst) begin
         state_q  <= S_IDLE;
         item_q   <= '0;
         cid1_q   <= '0;
         cid2_q   <= '0;
         cid3_q   <= '0;
         hit_q    <= 1'b0;
         err_q    <= 1'b0;
         res_id_q <= FULL_ID;
         res_w_q  <= '0;
      end else begin
         state_q  <= state_d;
         item_q   <= item_d;
         cid1_q   <= cid1_d;
         cid2_q   <= cid2_d;
         cid3_q   <= cid3_d;
         hit_q    <= hit_d;
         err_q    <= err_d;
         res_id_q <= res_id_d;
         res_w_q  <= res_w_d;
      end
   end

   // Memory strobes decode straight from state, so a reset drops any pending write.
   assign in_ready        = (state_q == S_IDLE);
   assign out_valid       = (state_q == S_RESP);
   assign ram_en          = (state_q == S_RD) || (state_q == S_WR);
   assign ram_we          = (state_q == S_WR);
   assign ram_id1         = (state_q == S_RD) ? cid1_q : '0;
   assign ram_id2         = (state_q == S_RD) ? cid2_q : '0;
   assign ram_id3         = (state_q == S_RD) ? cid3_q : '0;
   assign ram_write_id    = (state_q == S_WR) ? res_id_q : '0;
   assign ram_write_width = (state_q == S_WR) ? item_q : '0;
   assign out_hit         = hit_q;
   assign out_err         = err_q;
   assign out_id          = res_id_q;
   assign out_new_width   = res_w_q;

endmodule

// File: tb/tb_occupancy_alloc_ctrl.sv
// Self-checking bench: occupied-width memory model plus a per-request reference
// that applies the placement rules directly to an array of occupancies.
module tb_occupancy_alloc_ctrl;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [4:0] item_width;
   logic [3:0] id1, id2, id3;
   logic       ram_en, ram_we;
   logic [3:0] ram_write_id;
   logic [4:0] ram_write_width;
   logic [3:0] ram_id1, ram_id2, ram_id3;
   logic [6:0] ram_width1, ram_width2, ram_width3;
   logic       out_valid, out_ready, out_hit, out_err;
   logic [3:0] out_id;
   logic [6:0] out_new_width;

   int checks;
   int failures;

   // Memory-side environment
   logic [6:0] mem [16];
   int         en_cnt, wr_cnt;
   int         last_wid, last_ww;
   logic       pre_en;
   logic [3:0] pre_id;
   logic [6:0] pre_val;

   // Reference occupancy state
   int model_mem [16];

   occupancy_alloc_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .item_width      (item_width),
      .id1             (id1),
      .id2             (id2),
      .id3             (id3),
      .ram_en          (ram_en),
      .ram_we          (ram_we),
      .ram_write_id    (ram_write_id),
      .ram_write_width (ram_write_width),
      .ram_id1         (ram_id1),
      .ram_id2         (ram_id2),
      .ram_id3         (ram_id3),
      .ram_width1      (ram_width1),
      .ram_width2      (ram_width2),
      .ram_width3      (ram_width3),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_hit         (out_hit),
      .out_id          (out_id),
      .out_new_width   (out_new_width),
      .out_err         (out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pre_en) begin
         mem[pre_id] <= pre_val;
      end else if (ram_en && ram_we) begin
         mem[ram_write_id] <= mem[ram_write_id] + 7'(ram_write_width);
         wr_cnt   <= wr_cnt + 1;
         last_wid <= int'(ram_write_id);
         last_ww  <= int'(ram_write_width);
      end
      if (ram_en && !ram_we) begin
         ram_width1 <= mem[ram_id1];
         ram_width2 <= mem[ram_id2];
         ram_width3 <= mem[ram_id3];
      end
      if (ram_en) en_cnt <= en_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic preset(input int id, input int val);
      @(negedge clk);
      pre_en  = 1'b1;
      pre_id  = 4'(id);
      pre_val = 7'(val);
      @(negedge clk);
      pre_en  = 1'b0;
      model_mem[id] = val;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 16; i++) preset(i, (i == 13) ? 127 : 0);
   endtask

   // One request end to end; `hold` cycles of back-pressure in the result phase.
   task automatic run_req(input int w, input int a, input int b, input int c, input int hold);
      int   cand [3];
      int   exp_lat, exp_id, exp_nw, exp_en, cyc, en0, wr0;
      logic exp_err, exp_hit;
      cand[0] = a; cand[1] = b; cand[2] = c;
      exp_err = (w < 4) || (w > 16);
      exp_hit = 1'b0;
      exp_id  = 13;
      exp_nw  = 0;
      if (!exp_err) begin
         for (int k = 0; k < 3; k++) begin
            if (!exp_hit && cand[k] <= 13 && model_mem[cand[k]] + w <= 127) begin
               exp_hit = 1'b1;
               exp_id  = cand[k];
               exp_nw  = model_mem[cand[k]] + w;
            end
         end
      end
      if (exp_hit) model_mem[exp_id] = exp_nw;
      exp_lat = exp_err ? 1 : (exp_hit ? 4 : 3);
      exp_en  = exp_err ? 0 : (exp_hit ? 2 : 1);

      en0 = en_cnt;
      wr0 = wr_cnt;
      @(negedge clk);
      check("accept_ready", in_ready, 1);
      in_valid   = 1'b1;
      item_width = 5'(w);
      id1 = 4'(a); id2 = 4'(b); id3 = 4'(c);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("latency", cyc + 1, exp_lat);
      check("err", out_err, exp_err);
      check("hit", out_hit, exp_hit);
      check("id", out_id, exp_id);
      check("new_width", out_new_width, exp_nw);

      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", out_valid, 1);
         check("hold_in_ready", in_ready, 0);
         check("hold_hit", out_hit, exp_hit);
         check("hold_id", out_id, exp_id);
         check("hold_nw", out_new_width, exp_nw);
         check("hold_err", out_err, exp_err);
         in_valid   = 1'b1;
         item_width = 5'($urandom_range(4, 16));
         id1 = 4'($urandom); id2 = 4'($urandom); id3 = 4'($urandom);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("release_valid", out_valid, 0);
      check("release_ready", in_ready, 1);
      check("en_strobes", en_cnt - en0, exp_en);
      check("wr_strobes", wr_cnt - wr0, exp_hit ? 1 : 0);
      if (exp_hit) begin
         check("wr_id", last_wid, exp_id);
         check("wr_width", last_ww, w);
      end
   endtask

   // Reset lands while the controller sits in CHK with a hit pending.
   task automatic reset_in_chk(input int w, input int a);
      int en0, wr0;
      en0 = en_cnt;
      wr0 = wr_cnt;
      @(negedge clk);
      in_valid   = 1'b1;
      item_width = 5'(w);
      id1 = 4'(a); id2 = 4'(a); id3 = 4'(a);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rstchk_in_ready", in_ready, 1);
      check("rstchk_out_valid", out_valid, 0);
      check("rstchk_ram_en", ram_en, 0);
      check("rstchk_id", out_id, 13);
      check("rstchk_nw", out_new_width, 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rstchk_no_write", wr_cnt - wr0, 0);
      check("rstchk_one_read", en_cnt - en0, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks = 0; failures = 0;
      en_cnt = 0; wr_cnt = 0; last_wid = 0; last_ww = 0;
      pre_en = 1'b0; pre_id = '0; pre_val = '0;
      ram_width1 = '0; ram_width2 = '0; ram_width3 = '0;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      item_width = '0; id1 = '0; id2 = '0; id3 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_hit", out_hit, 0);
      check("rst_err", out_err, 0);
      check("rst_id", out_id, 13);
      check("rst_nw", out_new_width, 0);
      check("rst_ram", {ram_en, ram_we, ram_write_id, ram_write_width, ram_id1, ram_id2, ram_id3}, 0);
      rst = 1'b1;
      clear_mem();

      // Directed scenarios
      run_req(16, 3, 5, 7, 0);
      preset(3, 120);
      preset(5, 100);
      run_req(8, 3, 5, 7, 0);
      preset(2, 111);
      run_req(16, 2, 13, 13, 0);
      run_req(16, 2, 13, 13, 0);
      run_req(3, 1, 2, 3, 0);
      run_req(17, 1, 2, 3, 0);
      run_req(4, 14, 15, 6, 0);
      run_req(10, 6, 8, 9, 5);
      preset(4, 0);
      reset_in_chk(10, 4);
      run_req(10, 4, 4, 4, 0);

      // Randomized traffic against the reference occupancy array
      clear_mem();
      preset(14, 0);
      preset(15, 0);
      for (int n = 0; n < 150; n++) begin
         run_req(int'($urandom_range(2, 18)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 2)));
      end
      for (int i = 0; i < 14; i++) check("final_mem", mem[i], model_mem[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
